// File: rtl/m_output_port_allocator.sv
`default_nettype none
// ============================================================================
// Module      : m_output_port_allocator
// Description : Wormhole output-port allocator for one router output. Picks a
//               winner among requesting inputs with a matrix (least-recently-
//               granted) arbiter, locks the output to that input until its
//               tail flit passes, and gates every transfer on downstream
//               credits.
// Ports       : CLK            - clock, all state updates on rising edge
//               RST            - synchronous active-high reset
//               request_vector - per-input "holds a flit for this output"
//               tail_vector    - per-input "current flit is a tail"
//               credit_in      - one downstream buffer slot freed
//               grant_vector   - one-hot/zero transfer grant (combinational)
//               owner_vector   - registered one-hot packet owner in LOCKED
//               busy           - high while a packet owns the output
//               credit_count   - available downstream credits
//               credit_err     - sticky credit-overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module m_output_port_allocator #(
    parameter int N_REQ     = 5,
    parameter int BUF_DEPTH = 4,
    localparam int CW       = $clog2(BUF_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] request_vector,
    input  logic [N_REQ-1:0] tail_vector,
    input  logic             credit_in,
    output logic [N_REQ-1:0] grant_vector,
    output logic [N_REQ-1:0] owner_vector,
    output logic             busy,
    output logic [CW-1:0]    credit_count,
    output logic             credit_err
);

    localparam logic [0:0]    S_IDLE   = 1'b0;
    localparam logic [0:0]    S_LOCKED = 1'b1;
    localparam logic [CW-1:0] C_FULL   = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] C_ONE    = CW'(1);

    logic [0:0]                   r_state;
    logic [0:0]                   w_state_next;
    logic [N_REQ-1:0]             r_owner;
    logic [N_REQ-1:0]             w_owner_next;
    // r_w[i][j] = 1 means input i beats input j. Diagonal is always 0.
    logic [N_REQ-1:0][N_REQ-1:0]  r_w;
    logic [N_REQ-1:0]             w_blocked;
    logic [N_REQ-1:0]             w_winner;
    logic [N_REQ-1:0]             w_grant;
    logic [CW-1:0]                r_credit;
    logic                         r_err;
    logic                         w_has_credit;
    logic                         w_granted;
    logic                         w_grant_tail;

    assign w_has_credit = (r_credit != '0);
    assign w_granted    = |w_grant;
    assign w_grant_tail = |(w_grant & tail_vector);

    // An input is blocked when some other active requester beats it.
    always_comb begin
        w_blocked = '0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if ((j != i) && request_vector[j] && r_w[j][i]) begin
                    w_blocked[i] = 1'b1;
                end
            end
        end
        w_winner = request_vector & ~w_blocked;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_owner <= '0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        case (r_state)
            S_IDLE: begin
                // A head flit without tail opens a multi-flit packet.
                if (w_granted && !w_grant_tail) begin
                    w_state_next = S_LOCKED;
                    w_owner_next = w_grant;
                end
            end
            S_LOCKED: begin
                if (w_granted && w_grant_tail) begin
                    w_state_next = S_IDLE;
                    w_owner_next = '0;
                end
            end
        endcase
    end

    // Output logic: grant is zero-latency from registered state and inputs.
    always_comb begin
        w_grant = '0;
        if (!RST && w_has_credit) begin
            if (r_state == S_IDLE) begin
                w_grant = w_winner;
            end else begin
                w_grant = r_owner & request_vector;
            end
        end
    end

    // Priority matrix: an IDLE grant demotes the winner to lowest priority.
    // Only row/column of the winner change, so W[j][i] = ~W[i][j] is kept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N_REQ; i++) begin
                for (int j = 0; j < N_REQ; j++) begin
                    r_w[i][j] <= (i < j);
                end
            end
        end else if ((r_state == S_IDLE) && w_granted) begin
            for (int i = 0; i < N_REQ; i++) begin
                for (int j = 0; j < N_REQ; j++) begin
                    if (i != j) begin
                        if (w_grant[i]) begin
                            r_w[i][j] <= 1'b0;
                        end else if (w_grant[j]) begin
                            r_w[i][j] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Credit counter. Grant and returned credit in the same cycle cancel.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_credit <= C_FULL;
            r_err    <= 1'b0;
        end else if (w_granted && !credit_in) begin
            r_credit <= r_credit - C_ONE;
        end else if (!w_granted && credit_in) begin
            if (r_credit == C_FULL) begin
                r_err <= 1'b1;
            end else begin
                r_credit <= r_credit + C_ONE;
            end
        end
    end

    assign grant_vector = w_grant;
    assign owner_vector = r_owner;
    assign busy         = r_state;
    assign credit_count = r_credit;
    assign credit_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_m_output_port_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_output_port_allocator
// Description : Self-checking bench for m_output_port_allocator. Directed
//               scenarios followed by random traffic, all compared against a
//               reference model that keeps priority as an ordered list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_output_port_allocator;

    localparam int N  = 5;
    localparam int BD = 4;
    localparam int CW = $clog2(BD + 1);

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [N-1:0]  request_vector = '0;
    logic [N-1:0]  tail_vector = '0;
    logic          credit_in = 1'b0;
    logic [N-1:0]  grant_vector;
    logic [N-1:0]  owner_vector;
    logic          busy;
    logic [CW-1:0] credit_count;
    logic          credit_err;

    int total = 0;
    int bad   = 0;

    // Reference model: priority as a list, highest first.
    int m_order[$];
    bit m_locked;
    int m_owner;
    int m_credit;
    bit m_err;

    m_output_port_allocator #(.N_REQ(N), .BUF_DEPTH(BD)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .request_vector (request_vector),
        .tail_vector    (tail_vector),
        .credit_in      (credit_in),
        .grant_vector   (grant_vector),
        .owner_vector   (owner_vector),
        .busy           (busy),
        .credit_count   (credit_count),
        .credit_err     (credit_err)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_order.delete();
        for (int k = 0; k < N; k++) m_order.push_back(k);
        m_locked = 1'b0;
        m_owner  = 0;
        m_credit = BD;
        m_err    = 1'b0;
    endtask

    function automatic logic [N-1:0] model_grant(input logic rst, input logic [N-1:0] req);
        logic [N-1:0] g;
        g = '0;
        if (rst || m_credit == 0) return g;
        if (m_locked) begin
            if (req[m_owner]) g[m_owner] = 1'b1;
            return g;
        end
        for (int k = 0; k < m_order.size(); k++) begin
            if (req[m_order[k]]) begin
                g[m_order[k]] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check grant before the edge, update
    // the model on the edge, check registered outputs after it. A non-negative
    // 'want' additionally checks the grant against a hand-derived constant.
    task automatic step(input logic rst, input logic [N-1:0] req, input logic [N-1:0] tail,
                        input logic cin, input int want);
        logic [N-1:0] eg;
        int idx;
        @(negedge CLK);
        RST = rst;
        request_vector = req;
        tail_vector = tail;
        credit_in = cin;
        #1;
        eg = model_grant(rst, req);
        check("grant", 32'(grant_vector), 32'(eg));
        if (want >= 0) check("dir_grant", 32'(grant_vector), want);
        @(posedge CLK);
        if (rst) begin
            model_reset();
        end else begin
            if (eg != '0) begin
                idx = 0;
                for (int k = 0; k < N; k++) if (eg[k]) idx = k;
                if (!m_locked) begin
                    for (int k = 0; k < m_order.size(); k++) begin
                        if (m_order[k] == idx) begin
                            m_order.delete(k);
                            break;
                        end
                    end
                    m_order.push_back(idx);
                    if (!tail[idx]) begin
                        m_locked = 1'b1;
                        m_owner  = idx;
                    end
                end else if (tail[idx]) begin
                    m_locked = 1'b0;
                end
            end
            if (eg != '0 && !cin) m_credit--;
            else if (eg == '0 && cin) begin
                if (m_credit == BD) m_err = 1'b1;
                else m_credit++;
            end
        end
        #1;
        check("busy", 32'(busy), 32'(m_locked));
        check("owner", 32'(owner_vector), m_locked ? (32'd1 << m_owner) : 32'd0);
        check("credit", 32'(credit_count), m_credit);
        check("err", 32'(credit_err), 32'(m_err));
    endtask

    initial begin
        model_reset();
        step(1'b1, '0, '0, 1'b0, 0);
        check("rst_credit", 32'(credit_count), BD);
        check("rst_busy", 32'(busy), 0);

        // Simultaneous single-flit packets
        step(1'b0, 5'b10110, 5'b11111, 1'b0, 5'b00010);
        step(1'b0, 5'b10110, 5'b11111, 1'b0, 5'b00100);
        step(1'b0, 5'b10110, 5'b11111, 1'b0, 5'b10000);
        step(1'b0, 5'b10110, 5'b11111, 1'b0, 5'b00010);
        check("c034_zero", 32'(credit_count), 0);
        step(1'b0, 5'b10110, 5'b11111, 1'b0, 0);

        // Packet lock: input 3 three flits, input 0 waiting
        step(1'b1, '0, '0, 1'b0, 0);
        step(1'b0, 5'b01000, 5'b00000, 1'b0, 5'b01000);
        check("lock_owner", 32'(owner_vector), 5'b01000);
        check("lock_busy", 32'(busy), 1);
        step(1'b0, 5'b01001, 5'b00000, 1'b0, 5'b01000);
        step(1'b0, 5'b01001, 5'b01000, 1'b0, 5'b01000);
        check("unlock_busy", 32'(busy), 0);
        step(1'b0, 5'b00001, 5'b00001, 1'b0, 5'b00001);

        // Credit stall while locked to input 2
        step(1'b1, '0, '0, 1'b0, 0);
        for (int k = 0; k < 4; k++) step(1'b0, 5'b00100, 5'b00000, 1'b0, 5'b00100);
        step(1'b0, 5'b00100, 5'b00000, 1'b0, 0);
        step(1'b0, 5'b00100, 5'b00000, 1'b1, 0);
        check("stall_credit1", 32'(credit_count), 1);
        step(1'b0, 5'b00100, 5'b00000, 1'b0, 5'b00100);
        step(1'b0, 5'b00100, 5'b00000, 1'b0, 0);

        // Reset mid-packet (owner 2)
        step(1'b1, 5'b00101, 5'b00000, 1'b0, 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_owner", 32'(owner_vector), 0);
        check("midrst_credit", 32'(credit_count), BD);
        step(1'b0, 5'b00101, 5'b00101, 1'b0, 5'b00001);

        // Grant and credit_in together at credit 2
        step(1'b1, '0, '0, 1'b0, 0);
        step(1'b0, 5'b00001, 5'b00001, 1'b0, 5'b00001);
        step(1'b0, 5'b00001, 5'b00001, 1'b0, 5'b00001);
        step(1'b0, 5'b00001, 5'b00001, 1'b1, 5'b00001);
        check("both_credit2", 32'(credit_count), 2);

        // Credit overflow
        step(1'b1, '0, '0, 1'b0, 0);
        step(1'b0, '0, '0, 1'b1, 0);
        check("ovf_credit", 32'(credit_count), BD);
        check("ovf_err", 32'(credit_err), 1);
        step(1'b0, '0, '0, 1'b0, 0);
        check("ovf_sticky", 32'(credit_err), 1);
        step(1'b1, '0, '0, 1'b0, 0);
        check("ovf_cleared", 32'(credit_err), 0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) == 0), N'($urandom), N'($urandom),
                 ($urandom_range(0, 2) == 0), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
